// File: rtl/fazyrv_ccx_unit.sv
// Chunk-serial custom-instruction unit for FazyRV: operands arrive LSB-first,
// CHUNKSIZE bits per cycle. Results return on the same chunked bus, with resp_o marking the last chunk.
module fazyrv_ccx_unit #(
  parameter int WIDTH     = 32,
  parameter int CHUNKSIZE = 4,
  parameter int RES_DLY   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [2:0]           sel_i,
  input  logic [CHUNKSIZE-1:0] rs_a_i,
  input  logic [CHUNKSIZE-1:0] rs_b_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 resp_o,
  output logic                 busy_o
);

  localparam int NCHUNK = WIDTH / CHUNKSIZE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);
  localparam int MSB = CHUNKSIZE - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;

  typedef enum logic [1:0] {IDLE, STREAM, EMIT, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q;
  logic            carry_q;
  logic            lt_q;

  logic                 accept;
  logic                 in_active;
  logic                 in_last;
  logic [2:0]           op;
  logic                 is_sub;
  logic                 deferred;
  logic                 cin;
  logic [CHUNKSIZE-1:0] b_eff;
  logic [CHUNKSIZE:0]   sum;
  logic                 ovf;
  logic                 lt_now;
  logic [CHUNKSIZE-1:0] chunk_res;

  logic                 s0_valid;
  logic                 s0_last;
  logic [CHUNKSIZE-1:0] s0_data;

  logic [CHUNKSIZE-1:0] pipe_data [RES_DLY];
  logic [RES_DLY-1:0]   pipe_valid;
  logic [RES_DLY-1:0]   pipe_last;

  // In the request cycle the live sel_i drives the datapath; afterwards the latched copy does.
  always_comb begin
    accept    = (state_q == IDLE) && req_i;
    in_active = accept || (state_q == STREAM);
    op        = (state_q == IDLE) ? sel_i : sel_q;
    is_sub    = (op == OP_SUB) || (op == OP_SLTU) || (op == OP_SLT);
    deferred  = (op == OP_SLTU) || (op == OP_SLT);
    in_last   = (state_q == IDLE) ? (LAST_IDX == '0) : (cnt_q == LAST_IDX);
    cin       = (state_q == IDLE) ? is_sub : carry_q;
    b_eff     = is_sub ? ~rs_b_i : rs_b_i;
    sum       = {1'b0, rs_a_i} + {1'b0, b_eff} + {{CHUNKSIZE{1'b0}}, cin};
    ovf       = (rs_a_i[MSB] == b_eff[MSB]) && (sum[MSB] != rs_a_i[MSB]);
    lt_now    = (op == OP_SLTU) ? ~sum[CHUNKSIZE] : (sum[MSB] ^ ovf);
    case (op)
      OP_AND:          chunk_res = rs_a_i & rs_b_i;
      OP_OR:           chunk_res = rs_a_i | rs_b_i;
      OP_XOR:          chunk_res = rs_a_i ^ rs_b_i;
      OP_ADD, OP_SUB:  chunk_res = sum[CHUNKSIZE-1:0];
      default:         chunk_res = '0;
    endcase
  end

  // Stage-0 source: live streaming results, or the zero-extended compare flag during EMIT.
  always_comb begin
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    s0_data  = '0;
    if (in_active && !deferred) begin
      s0_valid = 1'b1;
      s0_last  = in_last;
      s0_data  = chunk_res;
    end else if (state_q == EMIT) begin
      s0_valid = 1'b1;
      s0_last  = (cnt_q == LAST_IDX);
      s0_data  = (cnt_q == '0) ? CHUNKSIZE'(lt_q) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (in_last) begin
            cnt_d   = '0;
            state_d = deferred ? EMIT : FLUSH;
          end else begin
            cnt_d   = CW'(1);
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (in_last) begin
          cnt_d   = '0;
          state_d = deferred ? EMIT : FLUSH;
        end
      end
      EMIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (resp_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      carry_q <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        sel_q <= sel_i;
      end
      if (in_active) begin
        carry_q <= sum[CHUNKSIZE];
      end
      if (in_active && in_last) begin
        lt_q <= lt_now;
      end
    end
  end

  // Output pipeline; the last tag rides with its data so resp_o lines up with the final chunk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RES_DLY; i++) begin
        pipe_data[i]  <= '0;
        pipe_valid[i] <= 1'b0;
        pipe_last[i]  <= 1'b0;
      end
    end else begin
      pipe_data[0]  <= s0_data;
      pipe_valid[0] <= s0_valid;
      pipe_last[0]  <= s0_valid && s0_last;
      for (int i = 1; i < RES_DLY; i++) begin
        pipe_data[i]  <= pipe_data[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  assign res_o  = pipe_valid[RES_DLY-1] ? pipe_data[RES_DLY-1] : '0;
  assign resp_o = pipe_valid[RES_DLY-1] && pipe_last[RES_DLY-1];
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_fazyrv_ccx_unit.sv
// Scoreboard bench for fazyrv_ccx_unit: three parameter sets run the same directed
// program plus random ops; a per-instance monitor checks data, resp_o timing and busy_o.
module tb_fazyrv_ccx_unit;

  typedef struct {
    logic [31:0] expv;
    int          first;
    int          respc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Word-level reference for the eight operations.
  function automatic logic [31:0] refModel(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return {31'd0, (a < b)};
      3'b110:  return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CS  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int RD  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int NCH = 32 / CS;

    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [2:0]    sel = 3'b000;
    logic [CS-1:0] a = '0;
    logic [CS-1:0] b = '0;
    logic [CS-1:0] res;
    logic          resp;
    logic          busy;

    exp_t        sb[$];
    int          nextFree = 0;
    int          busyFrom = 1;
    int          busyTo = 0;
    int          idx;
    logic [31:0] got = '0;
    bit          done = 1'b0;

    fazyrv_ccx_unit #(.WIDTH(32), .CHUNKSIZE(CS), .RES_DLY(RD)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .sel_i  (sel),
      .rs_a_i (a),
      .rs_b_i (b),
      .res_o  (res),
      .resp_o (resp),
      .busy_o (busy)
    );

    // Issues one op at the earliest legal slot. stray >= 0 adds an ignored req on that
    // chunk; abortAt >= 0 asserts reset on that chunk and drops the expectation.
    task automatic applyStimulus(input string nm, input logic [2:0] s, input logic [31:0] av,
                                 input logic [31:0] bv, input int stray, input int abortAt);
      exp_t e;
      int   t0;
      bit   dfr;
      while (cyc < nextFree) begin
        @(posedge clk); #1;
      end
      t0      = cyc;
      dfr     = (s == 3'b101) || (s == 3'b110);
      e.expv  = refModel(s, av, bv);
      e.first = dfr ? t0 + NCH + RD : t0 + RD;
      e.respc = dfr ? t0 + 2 * NCH - 1 + RD : t0 + NCH - 1 + RD;
      e.name  = $sformatf("cfg%0d/%s", g, nm);
      sb.push_back(e);
      busyFrom = t0 + 1;
      busyTo   = e.respc;
      nextFree = e.respc + 1;
      for (int k = 0; k < NCH; k++) begin
        if (k == abortAt) begin
          rst = 1'b1;
          req = 1'b0;
          void'(sb.pop_back());
          busyTo = cyc - 1;
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst = 1'b0;
          nextFree = cyc;
          return;
        end
        req = (k == 0) || (k == stray);
        sel = (k == 0) ? s : ((k == stray) ? 3'b111 : ~s);
        a   = av[k*CS +: CS];
        b   = bv[k*CS +: CS];
        @(posedge clk); #1;
      end
      req = 1'b0;
      sel = 3'b000;
      a   = '0;
      b   = '0;
    endtask

    // Drives a single-cycle req at an absolute cycle; the DUT is expected to ignore it.
    task automatic pulseReq(input int atCycle);
      while (cyc < atCycle) begin
        @(posedge clk); #1;
      end
      req = 1'b1;
      sel = 3'b001;
      a   = '1;
      b   = '1;
      @(posedge clk); #1;
      req = 1'b0;
      sel = 3'b000;
      a   = '0;
      b   = '0;
    endtask

    always @(negedge clk) begin
      if (sb.size() > 0 && cyc >= sb[0].first && cyc <= sb[0].respc) begin
        idx = cyc - sb[0].first;
        got[idx*CS +: CS] = res;
        checkOutput({sb[0].name, " resp_timing"}, {31'd0, resp}, {31'd0, (cyc == sb[0].respc)});
        if (cyc == sb[0].respc) begin
          checkOutput({sb[0].name, " result"}, got, sb[0].expv);
          void'(sb.pop_front());
        end
      end else begin
        checkOutput($sformatf("cfg%0d/idle_res", g), {{(32-CS){1'b0}}, res}, 32'd0);
        checkOutput($sformatf("cfg%0d/idle_resp", g), {31'd0, resp}, 32'd0);
      end
      checkOutput($sformatf("cfg%0d/busy", g), {31'd0, busy},
                  {31'd0, (!rst && cyc >= busyFrom && cyc <= busyTo)});
    end

    initial begin
      logic [2:0]  rs;
      logic [31:0] ra, rb;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      nextFree = cyc;
      applyStimulus("and",       3'b000, 32'hF0F0_1234, 32'hFF00_FF0F, -1, -1);
      applyStimulus("or_stray",  3'b001, 32'h0F00_00F0, 32'h00F0_0F00, (NCH > 3) ? 3 : 1, -1);
      applyStimulus("add_carry", 3'b011, 32'h0000_00FF, 32'h0000_0001, -1, -1);
      applyStimulus("add_wrap",  3'b011, 32'hFFFF_FFFF, 32'h0000_0001, -1, -1);
      applyStimulus("sub_neg",   3'b100, 32'h0000_0000, 32'h0000_0001, -1, -1);
      applyStimulus("sub_pos",   3'b100, 32'h0000_0005, 32'h0000_0003, -1, -1);
      applyStimulus("slt_m1_1",  3'b110, 32'hFFFF_FFFF, 32'h0000_0001, -1, -1);
      applyStimulus("sltu_m1_1", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, -1, -1);
      applyStimulus("slt_ovf",   3'b110, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1);
      applyStimulus("sltu_1_m1", 3'b101, 32'h0000_0001, 32'hFFFF_FFFF, -1, -1);
      applyStimulus("reserved",  3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      applyStimulus("add_pre",   3'b011, 32'h1234_5678, 32'h1111_1111, -1, -1);
      pulseReq(nextFree - 1);
      applyStimulus("xor_next",  3'b010, 32'hAAAA_AAAA, 32'h5555_5555, -1, -1);
      applyStimulus("add_abort", 3'b011, 32'h0FFF_FFFF, 32'h0000_0001, -1, NCH / 2);
      applyStimulus("xor_post",  3'b010, 32'h1234_5678, 32'hFFFF_0000, -1, -1);
      for (int i = 0; i < 12; i++) begin
        rs = 3'($urandom_range(0, 7));
        ra = $urandom;
        rb = (i % 4 == 0) ? ra : $urandom;
        applyStimulus($sformatf("rand%0d_sel%0d", i, rs), rs, ra, rb, -1, -1);
      end
      for (int i = 0; i < 300 && sb.size() > 0; i++) begin
        @(posedge clk);
      end
      checkOutput($sformatf("cfg%0d/drain_empty", g), sb.size(), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    wait (cfg[0].done && cfg[1].done && cfg[2].done);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected all configs done");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fazyrv_ccx_unit.md
# fazyrv_ccx_unit

Chunk-serial custom-instruction (CCX) execution unit for the FazyRV exotiny core. It is the parametrised successor of the fixed AND-only bench responder. The core streams both source operands LSB-first, CHUNKSIZE bits per cycle. The unit returns the result on the same chunked bus, followed by a response strobe. It adds selectable operations, carry propagation across chunks, deferred-result (compare) operations, a configurable output pipeline depth and busy tracking; it sits between the core's CCX port and the eFPGA/bench pin mapping.

## Interface
Parameters:
- WIDTH, 32: operand width; must be a multiple of CHUNKSIZE.
- CHUNKSIZE, 4: bits per transfer cycle; legal values 1, 2, 4, 8. NCHUNK = WIDTH/CHUNKSIZE.
- RES_DLY, 1: output register stages; must be ≥ 1.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  start strobe; its cycle carries operand chunk 0.
- sel_i  in  3  operation; sampled only in the req_i cycle.
- rs_a_i  in  CHUNKSIZE  operand A chunk.
- rs_b_i  in  CHUNKSIZE  operand B chunk.
- res_o  out  CHUNKSIZE  result chunk.
- resp_o  out  1  one-cycle strobe coincident with the last result chunk.
- busy_o  out  1  unit owns the operation; new req_i is ignored while high.

## Operation
- Accepted request at cycle t0: req_i=1 and busy_o=0. Operand chunk k is presented at t0+k, for k = 0..NCHUNK-1.
- The unit latches sel_i at t0 and holds it until the operation completes.
- sel_i encodings:
  - 000 AND, 001 OR, 010 XOR: streaming.
  - 011 ADD: streaming, carry-in 0 at chunk 0.
  - 100 SUB: A + ~B, carry-in 1 at chunk 0.
  - 101 SLTU, 110 SLT: deferred.
  - 111 reserved: streaming, all-zero result.
- Carry register: loaded with the chunk carry-out each input cycle. Carry out of the top chunk is discarded, so results wrap mod 2^WIDTH.
- Deferred ops: compute A−B chunk-serially.
  - SLTU: lt = ~carry_out of the final chunk.
  - SLT: lt = N xor V, taken from the final chunk (sign bits of A, B and the difference).
  - Result value = lt zero-extended: chunk 0 = {0…, lt}, all other chunks 0.
- FSM states:
  - IDLE: on an accepted req, go to STREAM with chunk counter = 1.
  - STREAM: counts input chunks. After chunk NCHUNK-1, streaming ops go to FLUSH and deferred ops go to EMIT.
  - EMIT: generates NCHUNK internal output chunks (counter 0..NCHUNK-1), then goes to FLUSH.
  - FLUSH: waits until the tagged last chunk leaves the RES_DLY pipeline, then returns to IDLE.
- Internal chunk stream: each chunk carries a "last" tag. The tag travels through the RES_DLY stages alongside the data, and resp_o is the delayed tag.
- res_o is 0 whenever no valid chunk is at the pipeline output.
- req_i while busy_o=1 is ignored with no side effects. This includes the resp_o cycle.
- Reset mid-operation: all state is cleared, no resp_o is produced and in-flight data is discarded.

## Timing
- Reset values: res_o=0, resp_o=0, busy_o=0, FSM=IDLE, carry=0, pipeline=0.
- Streaming ops: result chunk k at res_o in cycle t0+k+RES_DLY. resp_o in cycle t0+NCHUNK-1+RES_DLY.
- Deferred ops: result chunk k in cycle t0+NCHUNK+k+RES_DLY. resp_o in cycle t0+2·NCHUNK-1+RES_DLY.
- busy_o: 1 from cycle t0+1 through the resp_o cycle inclusive; 0 again in the following cycle.
- Earliest next accepted req is the cycle after resp_o. Issued back-to-back, two streaming ops are separated by NCHUNK+RES_DLY cycles.
- Combinational chunk logic feeds pipeline stage 0. No combinational path exists from inputs to res_o or resp_o.

## Test plan
All scenarios use WIDTH=32, CHUNKSIZE=4, RES_DLY=1 unless stated.
- AND: A=0xF0F0_1234, B=0xFF00_FF0F → res 0xF000_1204 at t0+1..t0+8; resp_o exactly at t0+8; busy_o high t0+1..t0+8.
- ADD carry chain:
  - 0x0000_00FF+0x1 → 0x0000_0100.
  - 0xFFFF_FFFF+0x1 → 0x0000_0000 (wrap).
  - SUB 0x0−0x1 → 0xFFFF_FFFF.
- Deferred compares: A=0xFFFF_FFFF, B=0x1.
  - SLT → 0x1, SLTU → 0x0; chunks at t0+9..t0+16, resp_o at t0+16.
  - SLT with A=0x7FFF_FFFF, B=0x8000_0000 → 0x0.
- Protocol:
  - req_i pulsed at t0+3 of a running op → ignored; result and resp_o unchanged.
  - req in the resp_o cycle → ignored; req the next cycle → accepted.
  - sel=111 → all-zero result with normal resp_o timing.
- Reset: assert rst_i at t0+4 of an ADD → outputs 0 immediately, no resp_o; a new XOR after release completes correctly.
- Parameter sweep: (CHUNKSIZE=1, RES_DLY=3) and (CHUNKSIZE=8, RES_DLY=2) with random ops against a reference model; check resp_o cycle = t0+NCHUNK-1+RES_DLY for streaming ops and t0+2·NCHUNK-1+RES_DLY for deferred ops.
